// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the C_Memory data port between the CPU and the program loader.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE to cover the memory's 1-cycle read latency.
module dmem_port_arbiter #(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] TEXT_END = 10'd512
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic              o_cpu_err,
    input  logic              i_ldr_req,
    input  logic              i_ldr_we,
    input  logic [ADDR_W-1:0] i_ldr_addr,
    input  logic [DATA_W-1:0] i_ldr_wdata,
    output logic              o_ldr_ack,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_text_lock,
    output logic [ADDR_W-1:0] o_mem_addr_data,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_save,
    input  logic [DATA_W-1:0] i_mem_out_data,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic                r_last_gnt;
    logic                r_sel;
    logic                r_we;
    logic                r_blocked;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_grant;
    logic                w_gnt_sel;
    logic                w_gnt_we;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic [DATA_W-1:0]   w_gnt_wdata;
    logic                w_gnt_blocked;

    always_comb begin
        w_state_d = r_state;
        w_grant   = 1'b0;
        w_gnt_sel = 1'b0;
        unique case (r_state)
            StIdle: begin
                // On a tie the requester that did not win last time is served.
                if (i_cpu_req && i_ldr_req) begin
                    w_grant   = 1'b1;
                    w_gnt_sel = ~r_last_gnt;
                end else if (i_cpu_req) begin
                    w_grant   = 1'b1;
                    w_gnt_sel = 1'b0;
                end else if (i_ldr_req) begin
                    w_grant   = 1'b1;
                    w_gnt_sel = 1'b1;
                end
                if (w_grant) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: w_state_d = StWait;
            StWait:  w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_gnt_we      = w_gnt_sel ? i_ldr_we    : i_cpu_we;
        w_gnt_addr    = w_gnt_sel ? i_ldr_addr  : i_cpu_addr;
        w_gnt_wdata   = w_gnt_sel ? i_ldr_wdata : i_cpu_wdata;
        w_gnt_blocked = ~w_gnt_sel & w_gnt_we & i_text_lock & (w_gnt_addr < TEXT_END);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_last_gnt <= 1'b1;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_blocked  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_grant) begin
                r_last_gnt <= w_gnt_sel;
                r_sel      <= w_gnt_sel;
                r_we       <= w_gnt_we;
                r_blocked  <= w_gnt_blocked;
                r_addr     <= w_gnt_addr;
                r_wdata    <= w_gnt_wdata;
            end
            if (r_state == StWait && !r_we) begin
                r_rdata <= i_mem_out_data;
            end
        end
    end

    // Gating with reset keeps an ISSUE-cycle write from landing on the reset edge.
    assign o_mem_save       = (r_state == StIssue) & r_we & ~r_blocked & ~i_reset;
    assign o_mem_addr_data  = r_addr;
    assign o_mem_write_data = r_wdata;
    assign o_cpu_ack        = (r_state == StDone) & ~r_sel;
    assign o_ldr_ack        = (r_state == StDone) &  r_sel;
    assign o_cpu_err        = (r_state == StDone) & ~r_sel & r_blocked;
    assign o_rdata          = r_rdata;
    assign o_busy           = (r_state != StIdle);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural C_Memory data port model.
module tb_dmem_port_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic        i_cpu_req;
    logic        i_cpu_we;
    logic [9:0]  i_cpu_addr;
    logic [15:0] i_cpu_wdata;
    logic        o_cpu_ack;
    logic        o_cpu_err;
    logic        i_ldr_req;
    logic        i_ldr_we;
    logic [9:0]  i_ldr_addr;
    logic [15:0] i_ldr_wdata;
    logic        o_ldr_ack;
    logic [15:0] o_rdata;
    logic        i_text_lock;
    logic [9:0]  o_mem_addr_data;
    logic [15:0] o_mem_write_data;
    logic        o_mem_save;
    logic [15:0] i_mem_out_data;
    logic        o_busy;

    int n_cmp;
    int n_fail;

    logic [15:0] mem [0:1023];

    dmem_port_arbiter #(
        .ADDR_W  (10),
        .DATA_W  (16),
        .TEXT_END(10'd512)
    ) u_dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_cpu_req       (i_cpu_req),
        .i_cpu_we        (i_cpu_we),
        .i_cpu_addr      (i_cpu_addr),
        .i_cpu_wdata     (i_cpu_wdata),
        .o_cpu_ack       (o_cpu_ack),
        .o_cpu_err       (o_cpu_err),
        .i_ldr_req       (i_ldr_req),
        .i_ldr_we        (i_ldr_we),
        .i_ldr_addr      (i_ldr_addr),
        .i_ldr_wdata     (i_ldr_wdata),
        .o_ldr_ack       (o_ldr_ack),
        .o_rdata         (o_rdata),
        .i_text_lock     (i_text_lock),
        .o_mem_addr_data (o_mem_addr_data),
        .o_mem_write_data(o_mem_write_data),
        .o_mem_save      (o_mem_save),
        .i_mem_out_data  (i_mem_out_data),
        .o_busy          (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Synchronous-read memory: out_data follows the address one edge later.
    always @(posedge i_clk) begin
        if (o_mem_save) mem[o_mem_addr_data] <= o_mem_write_data;
        i_mem_out_data <= mem[o_mem_addr_data];
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_cpu_req   = 1'b0;
        i_cpu_we    = 1'b0;
        i_cpu_addr  = '0;
        i_cpu_wdata = '0;
        i_ldr_req   = 1'b0;
        i_ldr_we    = 1'b0;
        i_ldr_addr  = '0;
        i_ldr_wdata = '0;
        i_text_lock = 1'b0;
        step();
        step();
        i_reset = 1'b0;
    endtask

    // Runs one transaction from IDLE; ack_cyc is edges from request to ack (-1 = none).
    task automatic run_single(input logic ldr, input logic we, input logic [9:0] addr,
                              input logic [15:0] wd, output int ack_cyc, output int save_cnt,
                              output logic err, output logic [15:0] rd, output logic stray);
        ack_cyc  = -1;
        save_cnt = 0;
        err      = 1'b0;
        rd       = '0;
        stray    = 1'b0;
        if (ldr) begin
            i_ldr_req = 1'b1; i_ldr_we = we; i_ldr_addr = addr; i_ldr_wdata = wd;
        end else begin
            i_cpu_req = 1'b1; i_cpu_we = we; i_cpu_addr = addr; i_cpu_wdata = wd;
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            if (o_mem_save) save_cnt++;
            if (ldr ? o_cpu_ack : o_ldr_ack) stray = 1'b1;
            if (ldr ? o_ldr_ack : o_cpu_ack) begin
                ack_cyc = i;
                err     = o_cpu_err;
                rd      = o_rdata;
                break;
            end
        end
        i_cpu_req = 1'b0;
        i_ldr_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({o_cpu_ack, o_ldr_ack, o_cpu_err, o_mem_save, o_busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {o_cpu_ack, o_ldr_ack, o_cpu_err, o_mem_save, o_busy});
        end
        n_cmp++;
        if ({o_rdata, o_mem_addr_data, o_mem_write_data} !== 42'b0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want all 0",
                     o_rdata, o_mem_addr_data, o_mem_write_data);
        end
    endtask

    task automatic test_write_read();
        int ac, sc; logic er, st; logic [15:0] rd;
        do_reset();
        run_single(1'b0, 1'b1, 10'd5, 16'hBEEF, ac, sc, er, rd, st);
        n_cmp++;
        if (ac !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", ac); end
        n_cmp++;
        if (sc !== 1) begin n_fail++; $display("FAIL wr_save_cycles: got %0d want 1", sc); end
        n_cmp++;
        if (mem[5] !== 16'hBEEF) begin
            n_fail++; $display("FAIL wr_mem5: got %h want beef", mem[5]);
        end
        run_single(1'b0, 1'b0, 10'd5, 16'h0000, ac, sc, er, rd, st);
        n_cmp++;
        if (ac !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", ac); end
        n_cmp++;
        if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", rd); end
        n_cmp++;
        if (er !== 1'b0 || sc !== 0 || st !== 1'b0) begin
            n_fail++; $display("FAIL rd_side: err=%b save=%0d stray=%b want 0/0/0", er, sc, st);
        end
    endtask

    task automatic test_tie();
        int cpu_c, ldr_c;
        do_reset();
        cpu_c = -1; ldr_c = -1;
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 10'd1;
        i_ldr_req = 1'b1; i_ldr_we = 1'b0; i_ldr_addr = 10'd2;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (o_cpu_ack) begin cpu_c = i; i_cpu_req = 1'b0; end
            if (o_ldr_ack) begin ldr_c = i; i_ldr_req = 1'b0; break; end
        end
        i_cpu_req = 1'b0; i_ldr_req = 1'b0;
        step();
        n_cmp++;
        if (cpu_c !== 3) begin n_fail++; $display("FAIL tie_cpu_ack: got %0d want 3", cpu_c); end
        n_cmp++;
        if (ldr_c !== 7) begin n_fail++; $display("FAIL tie_ldr_ack: got %0d want 7", ldr_c); end
    endtask

    task automatic test_back_to_back();
        int k; int cyc [8]; logic seq [8]; logic both;
        do_reset();
        k = 0; both = 1'b0;
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 10'd3;
        i_ldr_req = 1'b1; i_ldr_we = 1'b0; i_ldr_addr = 10'd4;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (o_cpu_ack && o_ldr_ack) both = 1'b1;
            if (o_cpu_ack || o_ldr_ack) begin
                cyc[k] = i; seq[k] = o_ldr_ack; k++;
                if (k == 8) break;
            end
        end
        i_cpu_req = 1'b0; i_ldr_req = 1'b0;
        step();
        n_cmp++;
        if (k !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", k); end
        for (int j = 0; j < k; j++) begin
            n_cmp++;
            if (seq[j] !== j[0] || cyc[j] !== 3 + 4 * j) begin
                n_fail++;
                $display("FAIL b2b_ack%0d: got who=%b cyc=%0d want who=%b cyc=%0d",
                         j, seq[j], cyc[j], j[0], 3 + 4 * j);
            end
        end
        n_cmp++;
        if (both !== 1'b0) begin n_fail++; $display("FAIL b2b_concurrent: got 1 want 0"); end
    endtask

    task automatic test_text_lock();
        int ac, sc; logic er, st; logic [15:0] rd;
        do_reset();
        run_single(1'b1, 1'b1, 10'd10, 16'h5555, ac, sc, er, rd, st);
        i_text_lock = 1'b1;
        run_single(1'b0, 1'b1, 10'd10, 16'h1234, ac, sc, er, rd, st);
        n_cmp++;
        if (sc !== 0) begin n_fail++; $display("FAIL lock_save: got %0d want 0", sc); end
        n_cmp++;
        if (ac !== 3 || er !== 1'b1) begin
            n_fail++; $display("FAIL lock_ack_err: ack=%0d err=%b want 3/1", ac, er);
        end
        n_cmp++;
        if (mem[10] !== 16'h5555) begin
            n_fail++; $display("FAIL lock_mem10: got %h want 5555", mem[10]);
        end
        run_single(1'b1, 1'b1, 10'd10, 16'h1234, ac, sc, er, rd, st);
        n_cmp++;
        if (ac !== 3 || sc !== 1) begin
            n_fail++; $display("FAIL lock_ldr_wr: ack=%0d save=%0d want 3/1", ac, sc);
        end
        run_single(1'b0, 1'b0, 10'd10, 16'h0000, ac, sc, er, rd, st);
        n_cmp++;
        if (rd !== 16'h1234 || er !== 1'b0) begin
            n_fail++; $display("FAIL lock_readback: rd=%h err=%b want 1234/0", rd, er);
        end
        i_text_lock = 1'b0;
    endtask

    task automatic test_text_end();
        int ac, sc; logic er, st; logic [15:0] rd;
        do_reset();
        i_text_lock = 1'b1;
        run_single(1'b0, 1'b1, 10'd512, 16'h0F0F, ac, sc, er, rd, st);
        n_cmp++;
        if (sc !== 1 || er !== 1'b0) begin
            n_fail++; $display("FAIL text_end_wr: save=%0d err=%b want 1/0", sc, er);
        end
        n_cmp++;
        if (mem[512] !== 16'h0F0F) begin
            n_fail++; $display("FAIL text_end_mem: got %h want 0f0f", mem[512]);
        end
        run_single(1'b0, 1'b1, 10'd511, 16'hDEAD, ac, sc, er, rd, st);
        n_cmp++;
        if (sc !== 0 || er !== 1'b1) begin
            n_fail++; $display("FAIL text_511_wr: save=%0d err=%b want 0/1", sc, er);
        end
        i_text_lock = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int ac, sc; logic er, st; logic [15:0] rd; logic seen;
        do_reset();
        run_single(1'b1, 1'b1, 10'd20, 16'hAAAA, ac, sc, er, rd, st);
        i_ldr_req = 1'b1; i_ldr_we = 1'b1; i_ldr_addr = 10'd20; i_ldr_wdata = 16'h7777;
        step();
        i_reset = 1'b1;
        #1;
        n_cmp++;
        if (o_mem_save !== 1'b0) begin
            n_fail++; $display("FAIL rst_issue_save: got %b want 0", o_mem_save);
        end
        step();
        i_reset = 1'b0; i_ldr_req = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_mem_save !== 1'b0 || o_ldr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: busy=%b save=%b ack=%b want 0/0/0",
                     o_busy, o_mem_save, o_ldr_ack);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_ldr_ack || o_cpu_ack) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_ack: got 1 want 0"); end
        n_cmp++;
        if (mem[20] !== 16'hAAAA) begin
            n_fail++; $display("FAIL rst_mem20: got %h want aaaa", mem[20]);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_write_read();
        test_tie();
        test_back_to_back();
        test_text_lock();
        test_text_end();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
